hazard_stall_ctrl: RTL and testbench

Pipeline sequencing controller for the pipelined core. It sits in decode beside the forwarding logic and drives the PC and IF/ID write enables, the IF/ID flush and the ID/EX bubble insert. It handles three cases: load-use hazards that forwarding cannot cover, taken-branch flushes resolved in EX, and stalls while a multi-cycle multiply unit works on the instruction held in ID.

---
 rtl/hazard_stall_ctrl_if.sv | 49 ++++
 rtl/hazard_stall_ctrl.sv | 148 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl_if
// Groups the decode-stage hazard signals exchanged between the pipeline
// datapath (master) and the sequencing controller (slave).
//
//   master drives : rs1_IF_ID, rs2_IF_ID, useRs2_IF_ID, memRead_ID_EX,
//                   regWrite_ID_EX, writeAddress_ID_EX, branchTaken_EX,
//                   mulIssue_ID, mulDone
//   slave drives  : pcWrite, ifIdWrite, ifIdFlush, idExBubble, mulStart,
//                   busy, mulError, stallCycles[15:0]
// ---------------------------------------------------------------------------
interface hazard_stall_ctrl_if #(
    parameter int REG_ADDR_W = 3
);
    logic [REG_ADDR_W-1:0] rs1_IF_ID;
    logic [REG_ADDR_W-1:0] rs2_IF_ID;
    logic                  useRs2_IF_ID;
    logic                  memRead_ID_EX;
    logic                  regWrite_ID_EX;
    logic [REG_ADDR_W-1:0] writeAddress_ID_EX;
    logic                  branchTaken_EX;
    logic                  mulIssue_ID;
    logic                  mulDone;

    logic                  pcWrite;
    logic                  ifIdWrite;
    logic                  ifIdFlush;
    logic                  idExBubble;
    logic                  mulStart;
    logic                  busy;
    logic                  mulError;
    logic [15:0]           stallCycles;

    modport master (
        output rs1_IF_ID, rs2_IF_ID, useRs2_IF_ID, memRead_ID_EX,
               regWrite_ID_EX, writeAddress_ID_EX, branchTaken_EX,
               mulIssue_ID, mulDone,
        input  pcWrite, ifIdWrite, ifIdFlush, idExBubble, mulStart,
               busy, mulError, stallCycles
    );

    modport slave (
        input  rs1_IF_ID, rs2_IF_ID, useRs2_IF_ID, memRead_ID_EX,
               regWrite_ID_EX, writeAddress_ID_EX, branchTaken_EX,
               mulIssue_ID, mulDone,
        output pcWrite, ifIdWrite, ifIdFlush, idExBubble, mulStart,
               busy, mulError, stallCycles
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
// Decode-stage sequencing controller: load-use stalls, taken-branch flushes
// and stalls while the multi-cycle multiplier works on the ID instruction.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-high; forces all outputs to defaults
//   bus    - hazard_stall_ctrl_if.slave (hazard inputs, pipeline controls)
//
// Optional build macro: HAZARD_PERF_EN enables the saturating stall-cycle
// counter on bus.stallCycles; without it the output is tied to zero.
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int REG_ADDR_W   = 3,
    parameter int FLUSH_CYCLES = 1,
    parameter int MUL_TIMEOUT  = 32
) (
    input  logic                clk,
    input  logic                reset,
    hazard_stall_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {RUN, FLUSH, MUL_WAIT} state_e;

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST  = 8'(MUL_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [1:0] flushCnt_q, flushCnt_d;
    logic [7:0] waitCnt_q, waitCnt_d;
    logic       mulError_q, mulError_d;

    logic pcWrite, ifIdWrite, ifIdFlush, idExBubble, mulStart;
    logic loadUse;

    // Register 0 never creates a hazard; a nonzero destination match implies
    // the source is nonzero too.
    assign loadUse = bus.memRead_ID_EX && bus.regWrite_ID_EX &&
                     (bus.writeAddress_ID_EX != '0) &&
                     ((bus.rs1_IF_ID == bus.writeAddress_ID_EX) ||
                      (bus.useRs2_IF_ID && (bus.rs2_IF_ID == bus.writeAddress_ID_EX)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            flushCnt_q <= '0;
            waitCnt_q  <= '0;
            mulError_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            flushCnt_q <= flushCnt_d;
            waitCnt_q  <= waitCnt_d;
            mulError_q <= mulError_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        flushCnt_d = flushCnt_q;
        waitCnt_d  = waitCnt_q;
        mulError_d = mulError_q;
        pcWrite    = 1'b1;
        ifIdWrite  = 1'b1;
        ifIdFlush  = 1'b0;
        idExBubble = 1'b0;
        mulStart   = 1'b0;

        unique case (state_q)
            RUN: begin
                // Branch wins: any load-use in ID is flushed with it.
                if (bus.branchTaken_EX) begin
                    ifIdFlush  = 1'b1;
                    idExBubble = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d    = FLUSH;
                        flushCnt_d = FLUSH_INIT;
                    end
                end else if (loadUse) begin
                    // Single-cycle stall: the bubble in EX clears the hazard.
                    pcWrite    = 1'b0;
                    ifIdWrite  = 1'b0;
                    idExBubble = 1'b1;
                end else if (bus.mulIssue_ID) begin
                    mulStart   = 1'b1;
                    pcWrite    = 1'b0;
                    ifIdWrite  = 1'b0;
                    idExBubble = 1'b1;
                    state_d    = MUL_WAIT;
                    waitCnt_d  = '0;
                end
            end
            FLUSH: begin
                ifIdFlush  = 1'b1;
                idExBubble = 1'b1;
                flushCnt_d = flushCnt_q - 2'd1;
                if (flushCnt_q == 2'd1) state_d = RUN;
            end
            MUL_WAIT: begin
                waitCnt_d = waitCnt_q + 8'd1;
                if (bus.mulDone) begin
                    state_d = RUN;
                end else if (waitCnt_q == WAIT_LAST) begin
                    // Release exactly as on completion, but flag the error.
                    mulError_d = 1'b1;
                    state_d    = RUN;
                end else begin
                    pcWrite    = 1'b0;
                    ifIdWrite  = 1'b0;
                    idExBubble = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        if (reset) begin
            pcWrite    = 1'b1;
            ifIdWrite  = 1'b1;
            ifIdFlush  = 1'b0;
            idExBubble = 1'b0;
            mulStart   = 1'b0;
        end
    end

    assign bus.pcWrite    = pcWrite;
    assign bus.ifIdWrite  = ifIdWrite;
    assign bus.ifIdFlush  = ifIdFlush;
    assign bus.idExBubble = idExBubble;
    assign bus.mulStart   = mulStart;
    assign bus.busy       = !reset && (state_q != RUN);
    assign bus.mulError   = !reset && mulError_q;

`ifdef HAZARD_PERF_EN
    logic [15:0] stallCycles_q;

    // pcWrite is already forced high during reset, so reset cycles never count.
    always_ff @(posedge clk) begin
        if (reset)
            stallCycles_q <= '0;
        else if (!pcWrite && (stallCycles_q != 16'hFFFF))
            stallCycles_q <= stallCycles_q + 16'd1;
    end

    assign bus.stallCycles = reset ? 16'd0 : stallCycles_q;
`else
    assign bus.stallCycles = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
// Directed scenarios followed by randomized traffic, every cycle compared
// against a behavioural model that tracks "flush cycles left" and "cycles
// since multiply issue" as plain integers.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;
    localparam int AW = 3;
    localparam int FC = 2;
    localparam int MT = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.REG_ADDR_W(AW)) bus ();

    hazard_stall_ctrl #(.REG_ADDR_W(AW), .FLUSH_CYCLES(FC), .MUL_TIMEOUT(MT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // model state
    int flush_left = 0;
    int mul_age    = 0;
    bit err_m      = 1'b0;
    int perf_m     = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic idle();
        bus.rs1_IF_ID = '0; bus.rs2_IF_ID = '0; bus.useRs2_IF_ID = 1'b0;
        bus.memRead_ID_EX = 1'b0; bus.regWrite_ID_EX = 1'b0;
        bus.writeAddress_ID_EX = '0; bus.branchTaken_EX = 1'b0;
        bus.mulIssue_ID = 1'b0; bus.mulDone = 1'b0;
    endtask

    // One clock: predict, check at negedge, advance model at posedge.
    task automatic step();
        bit e_pc, e_ifid, e_fl, e_bub, e_st, e_busy, lu, rel, tmo;
        e_pc = 1; e_ifid = 1; e_fl = 0; e_bub = 0; e_st = 0; e_busy = 0;
        rel = 0; tmo = 0;
        lu = bus.memRead_ID_EX && bus.regWrite_ID_EX && bus.writeAddress_ID_EX != 0 &&
             (bus.rs1_IF_ID == bus.writeAddress_ID_EX ||
              (bus.useRs2_IF_ID && bus.rs2_IF_ID == bus.writeAddress_ID_EX));
        if (reset) begin
        end else if (flush_left > 0) begin
            e_fl = 1; e_bub = 1; e_busy = 1;
        end else if (mul_age > 0) begin
            e_busy = 1;
            tmo = !bus.mulDone && mul_age == MT;
            rel = bus.mulDone || tmo;
            if (!rel) begin e_pc = 0; e_ifid = 0; e_bub = 1; end
        end else if (bus.branchTaken_EX) begin
            e_fl = 1; e_bub = 1;
        end else if (lu) begin
            e_pc = 0; e_ifid = 0; e_bub = 1;
        end else if (bus.mulIssue_ID) begin
            e_pc = 0; e_ifid = 0; e_bub = 1; e_st = 1;
        end

        @(negedge clk);
        chk("pcWrite",    32'(bus.pcWrite),    32'(e_pc));
        chk("ifIdWrite",  32'(bus.ifIdWrite),  32'(e_ifid));
        chk("ifIdFlush",  32'(bus.ifIdFlush),  32'(e_fl));
        chk("idExBubble", 32'(bus.idExBubble), 32'(e_bub));
        chk("mulStart",   32'(bus.mulStart),   32'(e_st));
        chk("busy",       32'(bus.busy),       32'(e_busy));
        chk("mulError",   32'(bus.mulError),   32'(reset ? 1'b0 : err_m));
`ifdef HAZARD_PERF_EN
        chk("stallCycles", 32'(bus.stallCycles), reset ? 32'd0 : 32'(perf_m));
`else
        chk("stallCycles", 32'(bus.stallCycles), 32'd0);
`endif

        @(posedge clk);
        if (reset) begin
            flush_left = 0; mul_age = 0; err_m = 0; perf_m = 0;
        end else begin
            if (!e_pc && perf_m < 65535) perf_m++;
            if (flush_left > 0) flush_left--;
            else if (mul_age > 0) begin
                if (rel) begin
                    mul_age = 0;
                    if (tmo) err_m = 1;
                end else mul_age++;
            end else if (bus.branchTaken_EX) flush_left = FC - 1;
            else if (!lu && bus.mulIssue_ID) mul_age = 1;
        end
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (3) step();
        reset = 1'b0;
        step();

        // load-use on rs1
        bus.memRead_ID_EX = 1; bus.regWrite_ID_EX = 1;
        bus.writeAddress_ID_EX = 3'd3; bus.rs1_IF_ID = 3'd3;
        step();
        idle();
        step();
`ifdef HAZARD_PERF_EN
        chk("lu_perf", 32'(bus.stallCycles), 32'd1);
`endif

        // rs2 matches but unused; then address 0
        bus.memRead_ID_EX = 1; bus.regWrite_ID_EX = 1;
        bus.writeAddress_ID_EX = 3'd5; bus.rs2_IF_ID = 3'd5; bus.rs1_IF_ID = 3'd1;
        step();
        bus.writeAddress_ID_EX = 3'd0; bus.rs1_IF_ID = 3'd0;
        step();
        idle();
        step();

        // taken branch with a coincident load-use
        bus.branchTaken_EX = 1;
        bus.memRead_ID_EX = 1; bus.regWrite_ID_EX = 1;
        bus.writeAddress_ID_EX = 3'd2; bus.rs1_IF_ID = 3'd2;
        step();
        idle();
        bus.branchTaken_EX = 1;   // ignored while flushing
        chk("flush_busy", 32'(bus.busy), 32'd1);
        step();
        idle();
        step();

        // multiply with mulDone 4 cycles after mulStart
        bus.mulIssue_ID = 1;
        bus.mulDone = 1;          // coincides with issue: ignored
        step();
        bus.mulDone = 0;
        repeat (3) step();
        bus.mulDone = 1;
        step();
        idle();
        chk("mul_busy", 32'(bus.busy), 32'd0);
        step();

        // timeout
        bus.mulIssue_ID = 1;
        step();
        repeat (MT) step();
        idle();
        repeat (2) step();
        chk("mulError_sticky", 32'(bus.mulError), 32'd1);

        // reset in the middle of a multiply wait
        bus.mulIssue_ID = 1;
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_err",  32'(bus.mulError), 32'd0);
        step();
        idle();
        step();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset                  = ($urandom_range(99) == 0);
            bus.rs1_IF_ID          = AW'($urandom_range(7));
            bus.rs2_IF_ID          = AW'($urandom_range(7));
            bus.useRs2_IF_ID       = $urandom_range(1);
            bus.memRead_ID_EX      = ($urandom_range(2) == 0);
            bus.regWrite_ID_EX     = ($urandom_range(3) != 0);
            bus.writeAddress_ID_EX = AW'($urandom_range(7));
            bus.branchTaken_EX     = ($urandom_range(9) == 0);
            bus.mulIssue_ID        = ($urandom_range(5) == 0);
            bus.mulDone            = ($urandom_range(5) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
